// File: rtl/strip_id.sv
// Ingress TID/TUSER checker: verifies AM_DST and beat count per packet, strips the tags, forwards through a 1-deep slice.
// Optional STRIP_ID_DROP_BAD_EN: consume packets whose TID mismatches instead of forwarding them.
module strip_id #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 16,
  parameter int TID_WIDTH   = 16,
  parameter int TUSER_WIDTH = 16,
  parameter int ERR_WIDTH   = 16,
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [TDATA_WIDTH-1:0] in_TDATA,
  input  logic                   in_TVALID,
  output logic                   in_TREADY,
  input  logic [TDEST_WIDTH-1:0] in_TDEST,
  input  logic                   in_TLAST,
  input  logic [TKEEP_WIDTH-1:0] in_TKEEP,
  input  logic [TID_WIDTH-1:0]   in_TID,
  input  logic [TUSER_WIDTH-1:0] in_TUSER,
  output logic [TDATA_WIDTH-1:0] out_TDATA,
  output logic [TDEST_WIDTH-1:0] out_TDEST,
  output logic                   out_TLAST,
  output logic [TKEEP_WIDTH-1:0] out_TKEEP,
  output logic                   out_TVALID,
  input  logic                   out_TREADY,
  output logic [ERR_WIDTH-1:0]   err_len_cnt,
  output logic [ERR_WIDTH-1:0]   err_id_cnt,
  output logic [1:0]             err_sticky
);

  typedef enum logic [1:0] {IDLE, BODY, DRAIN, DROP} state_t;

  state_t                 state_q;
  logic [TUSER_WIDTH-1:0] exp_q;
  logic [TUSER_WIDTH:0]   cnt_q;
  logic                   id_bad_q, len_off_q;
  logic                   out_valid_q, out_last_q;
  logic [TDATA_WIDTH-1:0] out_data_q;
  logic [TDEST_WIDTH-1:0] out_dest_q;
  logic [TKEEP_WIDTH-1:0] out_keep_q;
  logic [ERR_WIDTH-1:0]   err_len_q, err_id_q;
  logic [1:0]             sticky_q;

  logic                   slice_ready, ready, acc, first, active, hdr_id_bad;
  logic                   cur_off, cur_idb, is_short, is_long, pkt_end;
  logic                   len_err, id_err, drop_pkt, fwd;
  logic [TUSER_WIDTH:0]   cur_k, cur_exp;
  state_t                 state_d;

  always_comb begin
    slice_ready = ~out_valid_q | out_TREADY;
    ready       = ~ap_rst & ((state_q == DRAIN) | (state_q == DROP) | slice_ready);
    acc         = in_TVALID & ready;
    first       = (state_q == IDLE);
    active      = (state_q != DRAIN);
    hdr_id_bad  = in_TID != in_TDATA[24 +: TID_WIDTH];
    cur_exp     = first ? {1'b0, in_TUSER} : {1'b0, exp_q};
    cur_off     = first ? (in_TUSER == '0) : len_off_q;
    cur_idb     = first ? hdr_id_bad : id_bad_q;
    cur_k       = first ? {{TUSER_WIDTH{1'b0}}, 1'b1} : cnt_q + 1'b1;
    // Beat-count checks use the 1-based index of the beat currently presented.
    is_short    = in_TLAST & (cur_k < cur_exp) & ~cur_off;
    is_long     = ~in_TLAST & (cur_k == cur_exp) & ~cur_off;
    pkt_end     = in_TLAST | is_long;
    len_err     = acc & active & pkt_end & (is_short | is_long | cur_off);
    id_err      = acc & active & pkt_end & cur_idb;
`ifdef STRIP_ID_DROP_BAD_EN
    drop_pkt    = first ? hdr_id_bad : (state_q == DROP);
`else
    drop_pkt    = 1'b0;
`endif
    fwd         = acc & ((state_q == IDLE) | (state_q == BODY)) & ~drop_pkt;
    state_d     = state_q;
    if (acc) begin
      if (state_q == DRAIN) begin
        if (in_TLAST) state_d = IDLE;
      end else if (is_long) begin
        state_d = DRAIN;
      end else if (in_TLAST) begin
        state_d = IDLE;
      end else begin
        state_d = drop_pkt ? DROP : BODY;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      cnt_q       <= '0;
      id_bad_q    <= 1'b0;
      len_off_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_keep_q  <= '0;
      err_len_q   <= '0;
      err_id_q    <= '0;
      sticky_q    <= '0;
    end else begin
      state_q <= state_d;
      if (slice_ready) begin
        out_valid_q <= fwd;
        if (fwd) begin
          out_data_q <= in_TDATA;
          out_dest_q <= in_TDEST;
          out_keep_q <= in_TKEEP;
          out_last_q <= in_TLAST | is_long;
        end
      end
      if (acc && first) begin
        exp_q     <= in_TUSER;
        cnt_q     <= {{TUSER_WIDTH{1'b0}}, 1'b1};
        id_bad_q  <= hdr_id_bad;
        len_off_q <= (in_TUSER == '0);
      end else if (acc && active && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (len_err) begin
        sticky_q[0] <= 1'b1;
        if (err_len_q != '1) err_len_q <= err_len_q + 1'b1;
      end
      if (id_err) begin
        sticky_q[1] <= 1'b1;
        if (err_id_q != '1) err_id_q <= err_id_q + 1'b1;
      end
    end
  end

  assign in_TREADY   = ready;
  assign out_TVALID  = out_valid_q;
  assign out_TDATA   = out_data_q;
  assign out_TDEST   = out_dest_q;
  assign out_TKEEP   = out_keep_q;
  assign out_TLAST   = out_last_q;
  assign err_len_cnt = err_len_q;
  assign err_id_cnt  = err_id_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_strip_id.sv
// Directed-vector bench for strip_id (ERR_WIDTH=4 build); expectations follow STRIP_ID_DROP_BAD_EN when defined.
module tb_strip_id;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [15:0] in_dest = '0, in_tid = '0, in_tuser = '0;
  logic [7:0]  in_keep = '0;
  logic [63:0] out_data;
  logic [15:0] out_dest;
  logic        out_last, out_valid, out_ready = 1'b1;
  logic [7:0]  out_keep;
  logic [3:0]  err_len, err_id;
  logic [1:0]  sticky;

  always #5 clk = ~clk;

  strip_id #(.TDATA_WIDTH(64), .TDEST_WIDTH(16), .TID_WIDTH(16), .TUSER_WIDTH(16), .ERR_WIDTH(4)) dut (
    .ap_clk(clk), .ap_rst(rst),
    .in_TDATA(in_data), .in_TVALID(in_valid), .in_TREADY(in_ready), .in_TDEST(in_dest),
    .in_TLAST(in_last), .in_TKEEP(in_keep), .in_TID(in_tid), .in_TUSER(in_tuser),
    .out_TDATA(out_data), .out_TDEST(out_dest), .out_TLAST(out_last), .out_TKEEP(out_keep),
    .out_TVALID(out_valid), .out_TREADY(out_ready),
    .err_len_cnt(err_len), .err_id_cnt(err_id), .err_sticky(sticky)
  );

  typedef struct {
    logic [63:0] data;
    logic [15:0] tid, tuser;
    logic        last, fwd, olast, chk;
    logic [3:0]  elen, eid;
    logic [1:0]  estk;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   checks = 0, errors = 0, pkt_no = 0, bp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet builder: nout beats are expected out, the last of them with TLAST.
  task automatic add_pkt(input logic [15:0] tuser, input logic [15:0] tid, input logic [15:0] hid,
                         input int nb, input int nout, input logic do_chk,
                         input logic [3:0] elen, input logic [3:0] eid, input logic [1:0] estk);
    vec_t v;
    pkt_no++;
    for (int i = 0; i < nb; i++) begin
      v.data  = {16'(pkt_no), 8'(i), (i == 0) ? hid : ~hid, 8'h3C, 8'(i) ^ 8'h5A, 8'(pkt_no)};
      v.tid   = (i == 0) ? tid : ~tid;
      v.tuser = (i == 0) ? tuser : 16'h0001;
      v.last  = (i == nb - 1);
      v.fwd   = (i < nout);
      v.olast = (i == nout - 1);
      v.chk   = do_chk && (i == nb - 1);
      v.elen  = elen;
      v.eid   = eid;
      v.estk  = estk;
      vq.push_back(v);
    end
  endtask

  task automatic set_ready();
    out_ready = (bp == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic check_out();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", 64'(out_last), 64'(e.last));
        chk("out_dest", 64'(out_dest), 64'(e.data[63:48]));
        chk("out_keep", 64'(out_keep), 64'(e.data[7:0]));
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      set_ready();
      #1 check_out();
    end
  endtask

  task automatic send_beat(input vec_t v);
    int  n = 0;
    bit  done = 0;
    exp_t e;
    @(negedge clk);
    in_data = v.data; in_tid = v.tid; in_tuser = v.tuser; in_last = v.last;
    in_dest = v.data[63:48]; in_keep = v.data[7:0]; in_valid = 1'b1;
    set_ready();
    while (!done) begin
      #1 check_out();
      if (in_ready) begin
        done = 1;
        if (v.fwd) begin
          e.data = v.data;
          e.last = v.olast;
          sb.push_back(e);
        end
      end
      @(posedge clk);
      if (!done) begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got no in_TREADY expected acceptance");
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
        set_ready();
      end
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] elen, input logic [3:0] eid, input logic [1:0] estk);
    idle_cycles(3);
    chk({tag, "_err_len"}, 64'(err_len), 64'(elen));
    chk({tag, "_err_id"}, 64'(err_id), 64'(eid));
    chk({tag, "_sticky"}, 64'(sticky), 64'(estk));
  endtask

  task automatic run_vectors(input logic lat_chk);
    for (int i = 0; i < vq.size(); i++) begin
      send_beat(vq[i]);
      if (lat_chk && i == 0) begin
        #1;
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_data", out_data, vq[0].data);
      end
      if (vq[i].chk) check_cnt("pkt", vq[i].elen, vq[i].eid, vq[i].estk);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_err_id", 64'(err_id), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nb4, nb;
    logic [3:0] lp;
`ifdef STRIP_ID_DROP_BAD_EN
    nb4 = 0;
`else
    nb4 = 2;
`endif
    do_reset();
    bp = 0;
    // tuser, tid, hdr-id, beats in, beats out, check, len, id, sticky
    add_pkt(16'd4, 16'h0012, 16'h0012, 4, 4, 1, 4'd0, 4'd0, 2'b00);
    add_pkt(16'd1, 16'h0012, 16'h0012, 1, 1, 1, 4'd0, 4'd0, 2'b00);
    add_pkt(16'd6, 16'h0012, 16'h0012, 2, 2, 1, 4'd1, 4'd0, 2'b01);
    add_pkt(16'd3, 16'h0012, 16'h0012, 5, 3, 1, 4'd2, 4'd0, 2'b01);
    add_pkt(16'd2, 16'h0005, 16'h0007, 2, nb4, 1, 4'd2, 4'd1, 2'b11);
    add_pkt(16'd2, 16'h0033, 16'h0033, 2, 2, 1, 4'd2, 4'd1, 2'b11);
    add_pkt(16'd0, 16'h0012, 16'h0012, 3, 3, 1, 4'd3, 4'd1, 2'b11);
    add_pkt(16'd1, 16'h0012, 16'h0012, 3, 1, 1, 4'd4, 4'd1, 2'b11);
    run_vectors(1'b1);

    do_reset();
    bp = 1;
    for (int p = 0; p < 100; p++) begin
      nb = $urandom_range(1, 8);
      add_pkt(16'(nb), 16'h00A0 + 16'(p), 16'h00A0 + 16'(p), nb, nb, 0, 4'd0, 4'd0, 2'b00);
    end
    run_vectors(1'b0);
    check_cnt("bp", 4'd0, 4'd0, 2'b00);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    do_reset();
    bp = 0;
    for (int p = 0; p < 19; p++) add_pkt(16'd3, 16'h0012, 16'h0012, 2, 2, 0, 4'd0, 4'd0, 2'b00);
    run_vectors(1'b0);
    lp = 4'hF;
    check_cnt("sat", lp, 4'd0, 2'b01);

    add_pkt(16'd4, 16'h0012, 16'h0012, 4, 4, 0, 4'd0, 4'd0, 2'b00);
    send_beat(vq[0]);
    send_beat(vq[1]);
    vq.delete();
    do_reset();
    add_pkt(16'd2, 16'h0044, 16'h0044, 2, 2, 1, 4'd0, 4'd0, 2'b00);
    run_vectors(1'b0);

    idle_cycles(5);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
